// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and helpers for the load/store sequencer
//   memtype_t   - MemType encoding (2'b11 is treated as word)
//   lsu_state_t - sequencer FSM states
//   size_bytes  - access size in bytes for a MemType code
package lsu_pkg;
   typedef enum logic [1:0] {MT_WORD = 2'b00, MT_BYTE = 2'b01, MT_HALF = 2'b10} memtype_t;
   typedef enum logic [1:0] {IDLE, ACC0, ACC1, DONE} lsu_state_t;
   function automatic logic [2:0] size_bytes(input logic [1:0] t);
      return (t == MT_BYTE) ? 3'd1 : (t == MT_HALF) ? 3'd2 : 3'd4;
   endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane steering for the load/store sequencer
//   mem_type/mem_sign/k   access size, load extension mode, byte offset
//   wdata                 right-justified store data
//   lo/hi                 read words of the lower/upper access (hi is 0 when not split)
//   be_lo/be_hi           byte enables for the lower/upper word
//   wd_lo/wd_hi           lane-shifted store data for the lower/upper word
//   rdata                 aligned and extended load result
//   split                 access crosses a word boundary
module lsu_align
   import lsu_pkg::*;
(
   input  logic [1:0]  mem_type,
   input  logic        mem_sign,
   input  logic [1:0]  k,
   input  logic [31:0] wdata,
   input  logic [31:0] lo,
   input  logic [31:0] hi,
   output logic [3:0]  be_lo,
   output logic [3:0]  be_hi,
   output logic [31:0] wd_lo,
   output logic [31:0] wd_hi,
   output logic [31:0] rdata,
   output logic        split
);
   logic [2:0]  sz;
   logic [3:0]  mask;
   logic [7:0]  be8;
   logic [63:0] w64;
   logic [31:0] r;
   always_comb begin
      sz    = size_bytes(mem_type);
      mask  = (sz == 3'd1) ? 4'b0001 : (sz == 3'd2) ? 4'b0011 : 4'b1111;
      be8   = {4'b0, mask} << k;
      w64   = {32'b0, wdata} << {k, 3'b0};
      r     = 32'({hi, lo} >> {k, 3'b0});
      split = ({1'b0, k} + sz) > 3'd4;
      // mem_sign=0 sign-extends, 1 zero-extends
      rdata = (sz == 3'd1) ? {{24{~mem_sign & r[7]}}, r[7:0]} :
              (sz == 3'd2) ? {{16{~mem_sign & r[15]}}, r[15:0]} : r;
   end
   assign be_lo = be8[3:0];
   assign be_hi = be8[7:4];
   assign wd_lo = w64[31:0];
   assign wd_hi = w64[63:32];
endmodule

// File: rtl/lsu_sequencer.sv
// lsu_sequencer: multi-cycle load/store sequencer between core and word-wide data memory
//   core side:   Req_i, MemWrite_i, MemType_i, MemSign_i, Addr_i, WriteData_i in;
//                ReadData_o, Done_o (1-cycle pulse), Stall_o, Fault_o out
//   memory side: Mem_Req_o, Mem_We_o, Mem_Addr_o (word), Mem_Be_o, Mem_WData_o out;
//                Mem_Ack_i, Mem_RData_i in
//   MISALIGN_SPLIT_EN: when defined, word-crossing accesses are split into two
//   memory accesses; otherwise they complete immediately with Fault_o.
module lsu_sequencer
   import lsu_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int MAX_WAIT   = 255
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  Req_i,
   input  logic                  MemWrite_i,
   input  logic [1:0]            MemType_i,
   input  logic                  MemSign_i,
   input  logic [ADDR_WIDTH-1:0] Addr_i,
   input  logic [DATA_WIDTH-1:0] WriteData_i,
   output logic [DATA_WIDTH-1:0] ReadData_o,
   output logic                  Done_o,
   output logic                  Stall_o,
   output logic                  Fault_o,
   output logic                  Mem_Req_o,
   output logic                  Mem_We_o,
   output logic [ADDR_WIDTH-3:0] Mem_Addr_o,
   output logic [3:0]            Mem_Be_o,
   output logic [DATA_WIDTH-1:0] Mem_WData_o,
   input  logic                  Mem_Ack_i,
   input  logic [DATA_WIDTH-1:0] Mem_RData_i
);
   localparam int CW = $clog2(MAX_WAIT + 1);
`ifdef MISALIGN_SPLIT_EN
   localparam bit SPLIT_EN = 1'b1;
`else
   localparam bit SPLIT_EN = 1'b0;
`endif
   lsu_state_t state, nxt;
   logic                  op_we, op_sign;
   logic [1:0]            op_type;
   logic [ADDR_WIDTH-1:0] op_addr;
   logic [31:0]           op_wdata, rdata0;
   logic [CW-1:0]         cnt;
   logic                  idle_sel, in_acc, nxt_acc, timeout, split, fault_nxt;
   logic                  cur_we, cur_sign;
   logic [1:0]            cur_type;
   logic [ADDR_WIDTH-1:0] cur_addr;
   logic [31:0]           cur_wdata, ld_lo, ld_hi, ld_data, rdata_nxt, wd_lo, wd_hi;
   logic [3:0]            be_lo, be_hi;
   // In IDLE the live request is steered so the first access can be issued on the accepting edge
   assign idle_sel  = state == IDLE;
   assign in_acc    = state == ACC0 || state == ACC1;
   assign timeout   = cnt == CW'(MAX_WAIT);
   assign cur_we    = idle_sel ? MemWrite_i  : op_we;
   assign cur_sign  = idle_sel ? MemSign_i   : op_sign;
   assign cur_type  = idle_sel ? MemType_i   : op_type;
   assign cur_addr  = idle_sel ? Addr_i      : op_addr;
   assign cur_wdata = idle_sel ? WriteData_i : op_wdata;
   // The upper word only contributes on the final ack of a split access
   assign ld_lo = state == ACC1 ? rdata0 : Mem_RData_i;
   assign ld_hi = state == ACC1 ? Mem_RData_i : '0;
   lsu_align u_align (
      .mem_type (cur_type),
      .mem_sign (cur_sign),
      .k        (cur_addr[1:0]),
      .wdata    (cur_wdata),
      .lo       (ld_lo),
      .hi       (ld_hi),
      .be_lo    (be_lo),
      .be_hi    (be_hi),
      .wd_lo    (wd_lo),
      .wd_hi    (wd_hi),
      .rdata    (ld_data),
      .split    (split)
   );
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state       <= IDLE;
         op_we       <= 1'b0;
         op_sign     <= 1'b0;
         op_type     <= '0;
         op_addr     <= '0;
         op_wdata    <= '0;
         rdata0      <= '0;
         cnt         <= '0;
         Mem_Req_o   <= 1'b0;
         Mem_We_o    <= 1'b0;
         Mem_Be_o    <= '0;
         Mem_Addr_o  <= '0;
         Mem_WData_o <= '0;
         Done_o      <= 1'b0;
         Fault_o     <= 1'b0;
         ReadData_o  <= '0;
      end else begin
         state <= nxt;
         if (idle_sel && Req_i) begin
            op_we    <= MemWrite_i;
            op_sign  <= MemSign_i;
            op_type  <= MemType_i;
            op_addr  <= Addr_i;
            op_wdata <= WriteData_i;
         end
         if (state == ACC0 && Mem_Ack_i) rdata0 <= Mem_RData_i;
         cnt <= (nxt_acc && nxt != state) ? '0 : (in_acc && !Mem_Ack_i) ? cnt + 1'b1 : cnt;
         Mem_Req_o <= nxt_acc;
         Mem_We_o  <= nxt_acc & cur_we;
         Mem_Be_o  <= !nxt_acc ? 4'b0 : (nxt == ACC1) ? be_hi : be_lo;
         if (nxt_acc) begin
            Mem_Addr_o  <= (nxt == ACC1) ? op_addr[ADDR_WIDTH-1:2] + 1'b1 : cur_addr[ADDR_WIDTH-1:2];
            Mem_WData_o <= (nxt == ACC1) ? wd_hi : wd_lo;
         end
         Done_o     <= nxt == DONE;
         Fault_o    <= fault_nxt;
         ReadData_o <= rdata_nxt;
      end
   end
   // An ack present together with the timeout is taken as completion
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = !Req_i ? IDLE : (!SPLIT_EN && split) ? DONE : ACC0;
         ACC0:    nxt = Mem_Ack_i ? ((SPLIT_EN && split) ? ACC1 : DONE) : timeout ? DONE : ACC0;
`ifdef MISALIGN_SPLIT_EN
         ACC1:    nxt = (Mem_Ack_i || timeout) ? DONE : ACC1;
`endif
         default: nxt = IDLE;
      endcase
   end
   always_comb begin
      nxt_acc   = nxt == ACC0 || nxt == ACC1;
      fault_nxt = nxt == DONE && ((idle_sel && Req_i) || (in_acc && !Mem_Ack_i));
      rdata_nxt = (nxt == DONE && in_acc && Mem_Ack_i && !op_we) ? ld_data : '0;
      Stall_o   = Req_i & ~Done_o;
   end
endmodule

// File: tb/tb_lsu_sequencer.sv
// tb_lsu_sequencer: scoreboard bench for lsu_sequencer with a small memory model
module tb_lsu_sequencer;
   import lsu_pkg::*;
   localparam int MAX_WAIT = 255;
   logic clk = 1'b0, rst = 1'b1, req = 1'b0, we = 1'b0, sign = 1'b0;
   logic [1:0]  mtype = 2'b00;
   logic [31:0] addr = '0, wdata = '0;
   logic [31:0] rdata, mem_wdata, mem_rdata;
   logic        done, stall, fault, mem_req, mem_we, mem_ack;
   logic [29:0] mem_addr;
   logic [3:0]  mem_be;
   logic        ack_en = 1'b1, use_hi = 1'b0;
   int          ack_delay = 0, wait_cnt = 0;
   logic [31:0] w0 = '0, w1 = '0;
   logic [29:0] hi_addr = '0;
   int          n_chk = 0, n_fail = 0;
   typedef struct {logic [29:0] a; logic [3:0] be; logic we; logic [31:0] wd;} acc_t;
   typedef struct {logic load; logic [31:0] rd; logic fault;} res_t;
   acc_t aq[$];
   res_t rq[$];
   acc_t ea;
   res_t er;
   always #5 clk = ~clk;
   assign mem_ack   = mem_req && ack_en && (wait_cnt >= ack_delay);
   assign mem_rdata = (use_hi && mem_addr == hi_addr) ? w1 : w0;
   always @(posedge clk) wait_cnt <= (mem_req && !mem_ack) ? wait_cnt + 1 : 0;
   lsu_sequencer dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .Req_i       (req),
      .MemWrite_i  (we),
      .MemType_i   (mtype),
      .MemSign_i   (sign),
      .Addr_i      (addr),
      .WriteData_i (wdata),
      .ReadData_o  (rdata),
      .Done_o      (done),
      .Stall_o     (stall),
      .Fault_o     (fault),
      .Mem_Req_o   (mem_req),
      .Mem_We_o    (mem_we),
      .Mem_Addr_o  (mem_addr),
      .Mem_Be_o    (mem_be),
      .Mem_WData_o (mem_wdata),
      .Mem_Ack_i   (mem_ack),
      .Mem_RData_i (mem_rdata)
   );
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic push_acc(input logic [29:0] a, input logic [3:0] be, input logic w, input logic [31:0] wd);
      acc_t e;
      e.a = a; e.be = be; e.we = w; e.wd = wd;
      aq.push_back(e);
   endtask
   task automatic push_res(input logic load, input logic [31:0] rd, input logic f);
      res_t e;
      e.load = load; e.rd = rd; e.fault = f;
      rq.push_back(e);
   endtask
   task automatic run_op(input logic w, input logic [1:0] t, input logic s, input logic [31:0] a,
                         input logic [31:0] d, input int exp_lat, output int lat);
      logic got;
      @(negedge clk);
      req = 1'b1; we = w; mtype = t; sign = s; addr = a; wdata = d;
      lat = 0;
      got = 1'b0;
      while (!got && lat < 600) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (lat == 1 && !done) check("stall_busy", stall, 1);
         got = done;
      end
      check("done_seen", got, 1);
      if (got) check("stall_done", stall, 0);
      if (exp_lat > 0) check("latency", lat, exp_lat);
      req = 1'b0;
   endtask
   always @(negedge clk) begin
      if (!rst && mem_req && mem_ack) begin
         if (aq.size() == 0) check("acc_unexpected", 1, 0);
         else begin
            ea = aq.pop_front();
            check("mem_addr", mem_addr, ea.a);
            check("mem_be", mem_be, ea.be);
            check("mem_we", mem_we, ea.we);
            if (ea.we) check("mem_wdata", mem_wdata, ea.wd);
         end
      end
      if (!rst && done) begin
         check("req_low_at_done", mem_req, 0);
         if (rq.size() == 0) check("done_unexpected", 1, 0);
         else begin
            er = rq.pop_front();
            check("fault", fault, er.fault);
            if (er.load || er.fault) check("rdata", rdata, er.rd);
         end
      end
   end
   initial begin
      int lat;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_done", done, 0);
      check("rst_fault", fault, 0);
      check("rst_req", mem_req, 0);
      check("rst_we", mem_we, 0);
      check("rst_be", mem_be, 0);
      check("rst_rdata", rdata, 0);
      rst = 1'b0;
      w0 = 32'hDEADBEEF;
      push_acc(30'h40, 4'b1111, 0, 0); push_res(1, 32'hDEADBEEF, 0);
      run_op(0, MT_WORD, 0, 32'h100, 0, 2, lat);
      w0 = 32'h80123456;
      push_acc(30'h40, 4'b1000, 0, 0); push_res(1, 32'hFFFFFF80, 0);
      run_op(0, MT_BYTE, 0, 32'h103, 0, 2, lat);
      push_acc(30'h40, 4'b1000, 0, 0); push_res(1, 32'h00000080, 0);
      run_op(0, MT_BYTE, 1, 32'h103, 0, 2, lat);
      push_acc(30'h40, 4'b1100, 1, 32'hABCD0000); push_res(0, 0, 0);
      run_op(1, MT_HALF, 0, 32'h102, 32'h1234ABCD, 2, lat);
      w0 = 32'h80017777;
      push_acc(30'h80, 4'b1100, 0, 0); push_res(1, 32'hFFFF8001, 0);
      run_op(0, MT_HALF, 0, 32'h202, 0, 2, lat);
      push_acc(30'h40, 4'b0010, 1, 32'h0000A500); push_res(0, 0, 0);
      run_op(1, MT_BYTE, 0, 32'h101, 32'h000000A5, 2, lat);
      w0 = 32'h00007F00;
      push_acc(30'h0, 4'b0010, 0, 0); push_res(1, 32'h0000007F, 0);
      run_op(0, MT_BYTE, 0, 32'h001, 0, 2, lat);
      w0 = 32'h55667788;
      push_acc(30'h41, 4'b1111, 0, 0); push_res(1, 32'h55667788, 0);
      run_op(0, 2'b11, 0, 32'h104, 0, 2, lat);
`ifdef MISALIGN_SPLIT_EN
      w0 = 32'hAABB0000; w1 = 32'h0000CCDD; hi_addr = 30'h04000000; use_hi = 1'b1;
      push_acc(30'h03FFFFFF, 4'b1100, 0, 0); push_acc(30'h04000000, 4'b0011, 0, 0);
      push_res(1, 32'hCCDDAABB, 0);
      run_op(0, MT_WORD, 0, 32'h0FFFFFFE, 0, 3, lat);
      push_acc(30'h03FFFFFF, 4'b1110, 1, 32'h22334400); push_acc(30'h04000000, 4'b0001, 1, 32'h00000011);
      push_res(0, 0, 0);
      run_op(1, MT_WORD, 0, 32'h0FFFFFFD, 32'h11223344, 3, lat);
      w0 = 32'h12000000; w1 = 32'h00000034; hi_addr = 30'h0;
      push_acc(30'h3FFFFFFF, 4'b1000, 0, 0); push_acc(30'h0, 4'b0001, 0, 0);
      push_res(1, 32'h00003412, 0);
      run_op(0, MT_HALF, 1, 32'hFFFFFFFF, 0, 3, lat);
      use_hi = 1'b0;
`else
      push_res(1, 0, 1);
      run_op(0, MT_WORD, 0, 32'h0FFFFFFE, 0, 1, lat);
      push_res(0, 0, 1);
      run_op(1, MT_WORD, 0, 32'h0FFFFFFD, 32'h11223344, 1, lat);
      push_res(1, 0, 1);
      run_op(0, MT_HALF, 1, 32'hFFFFFFFF, 0, 1, lat);
`endif
      ack_delay = 5; w0 = 32'h0BADF00D;
      push_acc(30'h50, 4'b1111, 0, 0); push_res(1, 32'h0BADF00D, 0);
      run_op(0, MT_WORD, 0, 32'h140, 0, 7, lat);
      ack_delay = 0;
      ack_en = 1'b0;
      push_res(1, 0, 1);
      run_op(0, MT_WORD, 0, 32'h200, 0, 0, lat);
      check("timeout_lat", lat >= MAX_WAIT + 1 && lat <= MAX_WAIT + 2, 1);
      @(negedge clk);
      req = 1'b1; we = 1'b0; mtype = MT_WORD; addr = 32'h300;
      @(posedge clk);
      @(negedge clk);
      check("acc0_req", mem_req, 1);
      rst = 1'b1; req = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("midrst_req", mem_req, 0);
      check("midrst_done", done, 0);
      check("midrst_fault", fault, 0);
      check("midrst_be", mem_be, 0);
      check("midrst_we", mem_we, 0);
      rst = 1'b0; ack_en = 1'b1; w0 = 32'hCAFEF00D;
      push_acc(30'h40, 4'b1111, 0, 0); push_res(1, 32'hCAFEF00D, 0);
      run_op(0, MT_WORD, 0, 32'h100, 0, 2, lat);
      @(negedge clk);
      check("acc_queue_empty", aq.size(), 0);
      check("res_queue_empty", rq.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
